// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU control unit: opcodes, FSM state codes, A-source select.
package cpu_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // Execute states are 8 + opcode so DECODE can form them directly.
  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd8,
    S_STORE  = 4'd9,
    S_ADD    = 4'd10,
    S_SUB    = 4'd11,
    S_INPUT  = 4'd12,
    S_JZ     = 4'd13,
    S_JPOS   = 4'd14,
    S_HALT   = 4'd15
  } state_e;

  localparam logic [1:0] ASEL_ADD = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

endpackage

// File: rtl/enter_edge.sv
// Rising-edge detector for the operator Enter switch (already synchronous to Clock).
module enter_edge (
  input  logic Clock,
  input  logic Reset,
  input  logic Enter,
  output logic enter_rise
);

  logic enter_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      enter_d <= 1'b0;
    end else begin
      enter_d <= Enter;
    end
  end

  assign enter_rise = Enter & ~enter_d;

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU datapath.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 3,
  parameter int unsigned STW = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Enter,
  input  logic [OPW-1:0] opcode,
  input  logic           Aeq0,
  input  logic           Apos,
  output logic           IRload,
  output logic           JMPmux,
  output logic           PCload,
  output logic           Meminst,
  output logic           MemWr,
  output logic [1:0]     Asel,
  output logic           Aload,
  output logic           Sub,
  output logic           Halt,
  output logic [STW-1:0] outputState
);

  state_e state_q;
  logic   enter_rise;

  enter_edge u_enter_edge (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enter      (Enter),
    .enter_rise (enter_rise)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_START;
    end else begin
      case (state_q)
        S_START:  state_q <= S_FETCH;
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: state_q <= state_e'({1'b1, opcode[2:0]});
        S_INPUT:  state_q <= enter_rise ? S_START : S_INPUT;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_START;  // executes and illegal codes 3..7
      endcase
    end
  end

  assign outputState = STW'(state_q);

  // Controls are held at zero during Reset so a coincident Enter rise cannot load A.
  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = ASEL_ADD;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Halt    = 1'b0;
    if (!Reset) begin
      case (state_q)
        S_FETCH: begin
          Meminst = 1'b1;
          IRload  = 1'b1;
          PCload  = 1'b1;
        end
        S_LOAD: begin
          Asel  = ASEL_MEM;
          Aload = 1'b1;
        end
        S_STORE: MemWr = 1'b1;
        S_ADD:   Aload = 1'b1;
        S_SUB: begin
          Aload = 1'b1;
          Sub   = 1'b1;
        end
        S_INPUT: begin
          Asel  = ASEL_IN;
          Aload = enter_rise;
        end
        S_JZ: begin
          JMPmux = 1'b1;
          PCload = Aeq0;
        end
        S_JPOS: begin
          JMPmux = 1'b1;
          PCload = Apos;
        end
        S_HALT:  Halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
